// File: rtl/accel_sample_ring_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_sample_ring_writer_pkg
//  Description : Shared widths, memory size and FSM state type for the
//                accelerometer sample ring writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_sample_ring_writer_pkg;

  // Default bus geometry of the on-chip memory slave
  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 8;

  // Number of words in the target memory; no ring may extend past it
  localparam int MEM_WORDS_DEF  = 45000;

  // Writer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ring_state_t;

endpackage : accel_sample_ring_writer_pkg
`default_nettype wire

// File: rtl/accel_sample_ring_writer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : accel_sample_ring_writer_sync_fifo
//  Description : Single-clock show-ahead FIFO with a registered occupancy
//                count. The head entry is visible on dout whenever the FIFO
//                is not empty; pop consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_sample_ring_writer_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_idx;
  logic [PTR_W-1:0] r_rd_idx;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flags come straight from the registered count so callers never see a
  // combinational path from pop back to full.
  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_idx];

  // Read/write indices and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_idx <= r_wr_idx + PTR_W'(1);
      if (w_do_pop)  r_rd_idx <= r_rd_idx + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates use
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_idx] <= din;
  end

endmodule : accel_sample_ring_writer_sync_fifo
`default_nettype wire

// File: rtl/accel_sample_ring_writer.sv
`default_nettype none
// ============================================================================
//  Module      : accel_sample_ring_writer
//  Description : Avalon-MM write master that stores a valid/ready stream of
//                accelerometer samples into a circular window of on-chip
//                memory. A small FIFO absorbs interconnect stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_sample_ring_writer
  import accel_sample_ring_writer_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // sample stream
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  // configuration
  input  logic              cfg_enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  // Avalon-MM master
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  // status
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrap_pulse,
  output logic [31:0]       words_written,
  output logic              cfg_err,
  output logic              busy
);

  localparam logic [ADDR_W:0] c_mem_limit = (ADDR_W + 1)'(MEM_WORDS);

  ring_state_t       r_state;
  ring_state_t       w_state_nxt;
  logic              r_en_q;
  logic              w_en_rise;
  logic [ADDR_W:0]   w_window_end;
  logic              w_arm_bad;
  logic              w_arm_ok;
  logic              w_arm_err;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [31:0]       r_words;
  logic              r_cfg_err;
  logic              r_wrap;
  logic              w_push;
  logic              w_done;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_head;

  // Rising edge of the enable level, against last cycle's sampled value
  assign w_en_rise = cfg_enable && !r_en_q;

  // Window check is done one bit wider so base+len cannot wrap around
  assign w_window_end = {1'b0, cfg_base} + {1'b0, cfg_len};
  assign w_arm_bad    = (cfg_len == '0) || (w_window_end > c_mem_limit);

  // Ready follows the enable level so a stop request blocks input at once
  assign snk_ready = (r_state == RUN) && cfg_enable && !w_fifo_full;
  assign w_push    = snk_valid && snk_ready;

  // A write is presented whenever the FIFO holds a word; the head and the
  // pointer only move on completion, so everything holds under waitrequest.
  assign m_write       = (r_state != IDLE) && !w_fifo_empty;
  assign m_chipselect  = m_write;
  assign m_byteenable  = m_write ? 4'hF : 4'h0;
  assign m_address     = m_write ? r_wr_ptr : '0;
  assign m_writedata   = m_write ? w_head : '0;
  assign w_done        = m_write && !m_waitrequest;

  assign wr_ptr        = r_wr_ptr;
  assign wrap_pulse    = r_wrap;
  assign words_written = r_words;
  assign cfg_err       = r_cfg_err;
  assign busy          = (r_state != IDLE);

  accel_sample_ring_writer_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (snk_data),
    .pop   (w_done),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and arm decision
  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    w_arm_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_en_rise) begin
          if (w_arm_bad) begin
            w_arm_err = 1'b1;
          end else begin
            w_arm_ok    = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!cfg_enable) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Empty FIFO also means no write is on the bus
        if (w_fifo_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ring window, write pointer, counters and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_q    <= 1'b0;
      r_base    <= '0;
      r_last    <= '0;
      r_wr_ptr  <= '0;
      r_words   <= '0;
      r_cfg_err <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_en_q <= cfg_enable;
      r_wrap <= 1'b0;
      if (w_arm_err) r_cfg_err <= 1'b1;
      if (w_arm_ok) begin
        r_base    <= cfg_base;
        r_last    <= cfg_base + cfg_len - ADDR_W'(1);
        r_wr_ptr  <= cfg_base;
        r_words   <= '0;
        r_cfg_err <= 1'b0;
      end else if (w_done) begin
        if (r_words != '1) r_words <= r_words + 32'd1;
        if (r_wr_ptr == r_last) begin
          r_wr_ptr <= r_base;
          r_wrap   <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule : accel_sample_ring_writer
`default_nettype wire

// File: tb/tb_accel_sample_ring_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_sample_ring_writer
//  Description : Self-checking bench for accel_sample_ring_writer. A queue of
//                accepted-but-unwritten samples plus the ring geometry gives
//                the expected address, data, ready, write and wrap values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_sample_ring_writer;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          snk_valid;
  logic          snk_ready;
  logic [DW-1:0] snk_data;
  logic          cfg_enable;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len;
  logic [AW-1:0] m_address;
  logic          m_chipselect;
  logic          m_write;
  logic [3:0]    m_byteenable;
  logic [DW-1:0] m_writedata;
  logic          m_waitrequest;
  logic [AW-1:0] wr_ptr;
  logic          wrap_pulse;
  logic [31:0]   words_written;
  logic          cfg_err;
  logic          busy;

  always #5 clk = ~clk;

  accel_sample_ring_writer dut (
    .clk           (clk),
    .reset         (reset),
    .snk_valid     (snk_valid),
    .snk_ready     (snk_ready),
    .snk_data      (snk_data),
    .cfg_enable    (cfg_enable),
    .cfg_base      (cfg_base),
    .cfg_len       (cfg_len),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_byteenable  (m_byteenable),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .wr_ptr        (wr_ptr),
    .wrap_pulse    (wrap_pulse),
    .words_written (words_written),
    .cfg_err       (cfg_err),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] q[$];        // accepted samples not yet written
  int            mbase   = 0;
  int            mlen    = 1;
  int            n_done  = 0; // completed writes since arm
  int            wraps   = 0;
  bit            mrun    = 0; // ring is running with enable high
  bit            exp_wrap = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  bit            last_acc;
  bit            last_done;

  typedef struct {
    int base;
    int len;
    bit exp_err;
  } arm_vec_t;

  arm_vec_t av[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; sample at the falling edge,
  // update the model, then return just after the next rising edge.
  task automatic tick();
    logic          exp_ready;
    logic          exp_mw;
    int            ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    last_acc  = 0;
    last_done = 0;
    if (!reset) begin
      exp_ready = mrun && cfg_enable && (q.size() < DEPTH);
      exp_mw    = (q.size() != 0);
      chk("snk_ready", 64'(snk_ready), 64'(exp_ready));
      chk("m_write", 64'(m_write), 64'(exp_mw));
      chk("wrap_pulse", 64'(wrap_pulse), 64'(exp_wrap));
      chk("words_written", 64'(words_written), 64'(n_done));
      exp_wrap = 0;
      if (prev_stall)
        chk("stall_hold", {15'd0, m_write, m_address, m_writedata}, {15'd0, 1'b1, prev_addr, prev_data});
      if (m_write)
        chk("cs_byteenable", 64'({m_chipselect, m_byteenable}), 64'h1F);
      if (m_write && !m_waitrequest && q.size() != 0) begin
        ea = mbase + (n_done % mlen);
        ed = q.pop_front();
        chk("m_address", 64'(m_address), 64'(ea));
        chk("m_writedata", 64'(m_writedata), 64'(ed));
        if (ea == mbase + mlen - 1) begin
          exp_wrap = 1;
          wraps++;
        end
        n_done++;
        last_done = 1;
      end
      prev_stall = m_write && m_waitrequest;
      prev_addr  = m_address;
      prev_data  = m_writedata;
      if (snk_valid && snk_ready) begin
        q.push_back(snk_data);
        last_acc = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int base, input int len, input bit expect_ok);
    snk_valid  = 0;
    mrun       = 0;
    cfg_enable = 0;
    tick();
    cfg_base   = AW'(base);
    cfg_len    = AW'(len);
    cfg_enable = 1;
    tick();
    if (expect_ok) begin
      mbase  = base;
      mlen   = len;
      n_done = 0;
      wraps  = 0;
      mrun   = 1;
    end
    tick();
  endtask

  task automatic flush();
    int n = 0;
    snk_valid     = 0;
    m_waitrequest = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("flush_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic stop_and_wait();
    int n = 0;
    snk_valid     = 0;
    m_waitrequest = 0;
    cfg_enable    = 0;
    mrun          = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int k;
    int dcnt;
    int base;
    int len;

    reset         = 1;
    snk_valid     = 0;
    snk_data      = '0;
    cfg_enable    = 0;
    cfg_base      = '0;
    cfg_len       = '0;
    m_waitrequest = 0;
    #1;
    chk("rst_ctl", {22'd0, m_write, m_chipselect, m_byteenable, wrap_pulse, cfg_err, busy, snk_ready, m_address, wr_ptr}, 64'd0);
    chk("rst_data", {m_writedata, words_written}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    tick();

    // Arm acceptance table
    av[0] = '{16'h0100, 0,     1'b1};
    av[1] = '{44998,    3,     1'b1};
    av[2] = '{44998,    2,     1'b0};
    av[3] = '{0,        45000, 1'b0};
    av[4] = '{0,        45001, 1'b1};
    av[5] = '{16'hFFFF, 1,     1'b1};
    for (int i = 0; i < 6; i++) begin
      arm(av[i].base, av[i].len, !av[i].exp_err);
      chk("arm_cfg_err", 64'(cfg_err), 64'(av[i].exp_err));
      chk("arm_busy", 64'(busy), 64'(!av[i].exp_err));
      if (!av[i].exp_err) stop_and_wait();
    end

    // Small ring with wrap: six samples into four words
    arm(16'h0100, 4, 1);
    snk_valid = 1;
    k = 0;
    for (int g = 0; g < 20 && k < 6; g++) begin
      snk_data = 32'hA0 + k;
      tick();
      if (last_acc) k++;
    end
    flush();
    tick();
    chk("ring_words", 64'(words_written), 64'd6);
    chk("ring_wr_ptr", 64'(wr_ptr), 64'h102);
    chk("ring_wraps", 64'(wraps), 64'd1);
    stop_and_wait();

    // Long stall: FIFO fills, then drains one word per cycle
    arm(16'h0200, 16, 1);
    m_waitrequest = 1;
    snk_valid     = 1;
    k = 0;
    for (int g = 0; g < 12; g++) begin
      snk_data = 32'h11 + k;
      tick();
      if (last_acc) k++;
    end
    chk("stall_fill", 64'(k), 64'(DEPTH));
    chk("stall_ready_low", 64'(snk_ready), 64'd0);
    snk_valid     = 0;
    m_waitrequest = 0;
    dcnt = 0;
    for (int g = 0; g < DEPTH; g++) begin
      tick();
      if (last_done) dcnt++;
    end
    chk("stall_drain_b2b", 64'(dcnt), 64'(DEPTH));
    stop_and_wait();

    // Continuous stream with no stalls: one write per cycle after the first
    arm(16'h1000, 7, 1);
    snk_valid = 1;
    dcnt = 0;
    for (int g = 0; g < 50; g++) begin
      snk_data = $urandom;
      tick();
      if (last_done) dcnt++;
    end
    chk("stream_rate", 64'(dcnt), 64'd49);
    flush();
    stop_and_wait();

    // Randomized traffic against the model
    base = $urandom_range(0, 44000);
    len  = $urandom_range(1, 40);
    arm(base, len, 1);
    for (int g = 0; g < 400; g++) begin
      snk_valid     = ($urandom_range(0, 3) != 0);
      snk_data      = $urandom;
      m_waitrequest = ($urandom_range(0, 3) == 0);
      tick();
    end
    flush();
    tick();
    chk("rand_wr_ptr", 64'(wr_ptr), 64'(mbase + (n_done % mlen)));
    stop_and_wait();

    // Stop with three words queued behind a stall
    arm(16'h0300, 8, 1);
    m_waitrequest = 1;
    snk_valid     = 1;
    for (int g = 0; g < 3; g++) begin
      snk_data = 32'hC0 + g;
      tick();
    end
    cfg_enable = 0;
    mrun       = 0;
    #1;
    chk("stop_ready_now", 64'(snk_ready), 64'd0);
    tick();
    snk_valid     = 0;
    m_waitrequest = 0;
    dcnt = 0;
    for (int g = 0; g < 20 && busy; g++) begin
      tick();
      if (last_done) dcnt++;
    end
    chk("stop_drain_cnt", 64'(dcnt), 64'd3);
    chk("stop_busy", 64'(busy), 64'd0);

    // Reset while a write is stalled on the bus
    arm(16'h0400, 8, 1);
    m_waitrequest = 1;
    snk_valid     = 1;
    snk_data      = 32'hDEAD0001;
    tick();
    snk_data      = 32'hDEAD0002;
    tick();
    snk_valid = 0;
    chk("pre_rst_write", 64'(m_write), 64'd1);
    reset = 1;
    #1;
    chk("rst_mid_ctl", {22'd0, m_write, m_chipselect, m_byteenable, wrap_pulse, cfg_err, busy, snk_ready, m_address, wr_ptr}, 64'd0);
    chk("rst_mid_data", {m_writedata, words_written}, 64'd0);
    q.delete();
    n_done        = 0;
    mrun          = 0;
    exp_wrap      = 0;
    prev_stall    = 0;
    cfg_enable    = 0;
    m_waitrequest = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (3) tick();
    arm(16'h0010, 2, 1);
    snk_valid = 1;
    snk_data  = 32'h77;
    tick();
    flush();
    tick();
    chk("post_rst_words", 64'(words_written), 64'd1);
    stop_and_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_accel_sample_ring_writer
`default_nettype wire

// File: doc/accel_sample_ring_writer.md
Name: accel_sample_ring_writer

Overview:
- Avalon-MM master that writes a stream of 32-bit accelerometer samples into the on-chip memory slave (16-bit word address, 32-bit data), treating a configurable window of that memory as a circular buffer.
- Sits between the accelerometer sample source (valid/ready stream) and a master port on the system interconnect.
- Software reads the ring back through the Nios data master.
- Buffers samples in a small FIFO so interconnect waitrequest stalls do not back-pressure the sensor path immediately.

Parameters:
- ADDR_W, 16, word address width (matches memory address port)
- DATA_W, 32, sample/bus data width
- FIFO_DEPTH, 8, input FIFO entries (power of two, >=2)
- MEM_WORDS, 45000, words in target memory; upper bound for ring checks

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- snk_valid  in  1  sample valid
- snk_ready  out  1  sample accepted when valid&ready
- snk_data  in  DATA_W  sample word
- cfg_enable  in  1  level; rising edge arms the ring, falling edge stops it
- cfg_base  in  ADDR_W  ring start word address
- cfg_len  in  ADDR_W  ring length in words
- m_address  out  ADDR_W  word address
- m_chipselect  out  1  asserted with m_write
- m_write  out  1  write request
- m_byteenable  out  4  always 4'b1111 during write
- m_writedata  out  DATA_W  write data
- m_waitrequest  in  1  slave stall
- wr_ptr  out  ADDR_W  next address to be written
- wrap_pulse  out  1  one-cycle pulse when ring wraps
- words_written  out  32  saturating count of completed writes since arm
- cfg_err  out  1  sticky: last arm attempt rejected
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE, FIFO empty, all outputs 0; m_address=0, wr_ptr=0, words_written=0, cfg_err=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_enable rising edge (registered-edge detect) triggers an arm check.
  - If cfg_len==0 or cfg_base+cfg_len > MEM_WORDS (checked in ADDR_W+1 bits): set cfg_err, stay IDLE.
  - Otherwise: latch base/len, clear cfg_err, set wr_ptr=base and words_written=0, go RUN next cycle.
  - snk_ready=0 in IDLE.
- RUN:
  - snk_ready = FIFO not full. Push on snk_valid&snk_ready.
  - When FIFO non-empty and no write outstanding: next cycle drive m_write=m_chipselect=1, m_address=wr_ptr, m_writedata=FIFO head.
  - Hold address, data and controls stable while m_waitrequest=1.
  - Transfer completes on the cycle m_write & !m_waitrequest. On completion: pop FIFO, increment words_written (saturate at 2^32-1).
  - wr_ptr advances by 1; if wr_ptr == base+len-1 it reloads base and wrap_pulse=1 for that one cycle.
  - Back-to-back writes are allowed: m_write may stay high into the next transfer if the FIFO still has data after the pop, giving 1 word/cycle with waitrequest low.
  - Simultaneous push and pop on a full FIFO is legal only when not full at the sample point; ready is computed from the registered count, not a combinational pop.
- cfg_enable falling edge in RUN: go DRAIN. snk_ready=0; remaining FIFO words are still written. When the FIFO is empty and no write is pending, go IDLE.
- Rising edge of cfg_enable in DRAIN is ignored; software must wait for busy=0.
- cfg_base/cfg_len changes while not IDLE have no effect (latched copies are used).
- Reset mid-transfer: m_write drops immediately (async) and FIFO contents are discarded. The slave sees an abandoned write, which is acceptable for on-chip RAM.
- Latency:
  - Sample accepted at cycle N is on the bus (m_write=1) at N+1 at the earliest, when the FIFO was empty and no write is pending.
  - With m_waitrequest=0 that write completes at N+1.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, MEM_WORDS constant, state enum {IDLE, RUN, DRAIN}.
- One sub-module: sync_fifo (FIFO_DEPTH x DATA_W, registered count, full/empty flags, show-ahead head output).
- Top holds the FSM, pointer/wrap logic and the Avalon master.

Test Plan:
- Arm base=0x0100, len=4, push 6 samples 0xA0..0xA5, waitrequest=0 -> writes to 0x100,0x101,0x102,0x103,0x100,0x101; wrap_pulse once at the 4th write; words_written=6; wr_ptr=0x102.
- Arm base=44998, len=3 -> cfg_err=1, busy=0, no m_write; rearm with len=2 -> cfg_err=0, RUN.
- m_waitrequest held high 5 cycles during write of 0x11 -> m_address/m_writedata stable for all 5 cycles; FIFO fills to 8, snk_ready=0; after release, 8 words drain on consecutive cycles.
- Continuous snk_valid with waitrequest=0 -> one write per cycle after the first; snk_ready stays 1; no word lost or duplicated (scoreboard against memory model).
- Deassert cfg_enable with 3 words queued -> snk_ready=0 at once, 3 writes complete, then busy=0.
- Assert reset while m_write=1 under waitrequest -> m_write=0 same cycle, all outputs at reset values, FIFO empty after release.
